// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial symbol transmitter: COM preamble after reset, then IDLE filler or user bytes, MSB first.
// Optional realignment support is compiled in with PS_TX_REALIGN_EN.
module paralelo_serial_tx #(
    parameter int         COM_COUNT = 4,
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter logic [7:0] IDL_SYM   = 8'h7C
) (
    input  logic       clk_1,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       serial_out,
    output logic       sym_start,
    output logic       link_up
`ifdef PS_TX_REALIGN_EN
    ,
    input  logic       realign_req
`endif
);

    localparam logic [0:0] ST_COM  = 1'b0;
    localparam logic [0:0] ST_LINK = 1'b1;

    logic [0:0] state;
    logic [2:0] com_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       boundary;
    logic [3:0] com_nxt;
    logic       preamble_done;
    logic       realign_now;

    assign boundary      = (bit_cnt == 3'd7);
    assign com_nxt       = {1'b0, com_cnt} + 4'd1;
    assign preamble_done = (com_nxt >= 4'(COM_COUNT));

`ifdef PS_TX_REALIGN_EN
    logic realign_pend;

    // A request seen between boundaries is held until the next symbol boundary.
    assign realign_now = (state == ST_LINK) & (realign_req | realign_pend);

    always_ff @(posedge clk_1) begin
        if (reset) begin
            realign_pend <= 1'b0;
        end else if (boundary || state == ST_COM) begin
            realign_pend <= 1'b0;
        end else if (realign_req) begin
            realign_pend <= 1'b1;
        end
    end
`else
    assign realign_now = 1'b0;
`endif

    assign ready_out = (state == ST_LINK) & boundary & ~realign_now;

    always_ff @(posedge clk_1) begin
        if (reset) begin
            state      <= ST_COM;
            com_cnt    <= 3'd0;
            bit_cnt    <= 3'd0;
            shreg      <= COM_SYM;
            serial_out <= 1'b0;
            sym_start  <= 1'b0;
            link_up    <= 1'b0;
        end else begin
            serial_out <= shreg[3'd7 - bit_cnt];
            sym_start  <= (bit_cnt == 3'd0);
            bit_cnt    <= bit_cnt + 3'd1;
            // Next symbol is loaded on the edge that shifts out bit 0 of the current one.
            if (boundary) begin
                case (state)
                    ST_COM: begin
                        com_cnt <= com_nxt[2:0];
                        if (!preamble_done) begin
                            shreg <= COM_SYM;
                        end else begin
                            state   <= ST_LINK;
                            link_up <= 1'b1;
                            shreg   <= IDL_SYM;
                        end
                    end
                    default: begin
                        if (realign_now) begin
                            state   <= ST_COM;
                            com_cnt <= 3'd0;
                            link_up <= 1'b0;
                            shreg   <= COM_SYM;
                        end else if (valid_in) begin
                            shreg <= data_in;
                        end else begin
                            shreg <= IDL_SYM;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: preamble, data streaming, handshake window, reset abort.
module tb_paralelo_serial_tx;

    logic       clk_1 = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       serial_out;
    logic       sym_start;
    logic       link_up;
    logic       realign_req;

    int compared   = 0;
    int mismatched = 0;

    paralelo_serial_tx #(.COM_COUNT(4), .COM_SYM(8'hBC), .IDL_SYM(8'h7C)) dut (
        .clk_1      (clk_1),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .serial_out (serial_out),
        .sym_start  (sym_start),
        .link_up    (link_up)
`ifdef PS_TX_REALIGN_EN
        ,
        .realign_req(realign_req)
`endif
    );

    always #5 clk_1 = ~clk_1;

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one 8-cycle symbol; valid_in rises at bit index von and falls at voff (8 = untouched).
    task automatic sym(input string tag, input int von, input int voff, input logic [7:0] d,
                       input logic [7:0] exp_s, input logic [7:0] exp_rm);
        logic [7:0] s;
        logic [7:0] rm;
        logic       st;
        s  = 8'h00;
        rm = 8'h00;
        st = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == von) begin
                valid_in = 1'b1;
                data_in  = d;
            end
            if (i == voff) valid_in = 1'b0;
            tick();
            s[7-i] = serial_out;
            rm[i]  = ready_out;
            if (i == 0) st = sym_start;
        end
        check({tag, "_sym"}, s, exp_s);
        check({tag, "_start"}, {7'd0, st}, 8'd1);
        check({tag, "_ready"}, rm, exp_rm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int com_seen;
        logic idle_flag;
        reset       = 1'b1;
        data_in     = 8'h00;
        valid_in    = 1'b0;
        realign_req = 1'b0;
        tick();
        tick();
        check("rst_serial", {7'd0, serial_out}, 8'd0);
        check("rst_start", {7'd0, sym_start}, 8'd0);
        check("rst_link", {7'd0, link_up}, 8'd0);
        check("rst_ready", {7'd0, ready_out}, 8'd0);
        reset = 1'b0;

        // Preamble: four COMs, link_up only after the fourth boundary
        for (int k = 0; k < 4; k++) begin
            sym($sformatf("com%0d", k), 8, 8, 8'h00, 8'hBC, 8'h00);
            check($sformatf("com%0d_link", k), {7'd0, link_up}, (k == 3) ? 8'd1 : 8'd0);
        end
        sym("idle0", 8, 8, 8'h00, 8'h7C, 8'h40);
        sym("idle1", 8, 8, 8'h00, 8'h7C, 8'h40);

        // Continuous valid: back-to-back data with no IDLE between
        sym("a5_acc", 0, 8, 8'hA5, 8'h7C, 8'h40);
        sym("a5_0", 8, 8, 8'hA5, 8'hA5, 8'h40);
        sym("a5_1", 8, 8, 8'hA5, 8'hA5, 8'h40);
        valid_in = 1'b0;
        sym("a5_2", 8, 8, 8'hA5, 8'hA5, 8'h40);
        sym("a5_end", 8, 8, 8'h00, 8'h7C, 8'h40);

        // Single byte raised mid-symbol and held into the window
        sym("3c_acc", 3, 8, 8'h3C, 8'h7C, 8'h40);
        valid_in = 1'b0;
        sym("3c_data", 8, 8, 8'h00, 8'h3C, 8'h40);
        sym("3c_end", 8, 8, 8'h00, 8'h7C, 8'h40);

        // valid dropped before the window: nothing sent
        sym("miss_acc", 2, 5, 8'h55, 8'h7C, 8'h40);
        sym("miss_data", 8, 8, 8'h00, 8'h7C, 8'h40);

        // COM and IDLE values as data go out verbatim
        sym("verb_acc", 0, 8, 8'hBC, 8'h7C, 8'h40);
        sym("verb_bc", 0, 8, 8'h7C, 8'hBC, 8'h40);
        valid_in = 1'b0;
        sym("verb_7c", 8, 8, 8'h00, 8'h7C, 8'h40);
        check("verb_link", {7'd0, link_up}, 8'd1);

        // Reset in the middle of a data symbol
        sym("rst_acc", 0, 8, 8'hA5, 8'h7C, 8'h40);
        valid_in = 1'b0;
        tick();
        tick();
        tick();
        check("mid_bit5", {7'd0, serial_out}, 8'd1);
        reset = 1'b1;
        tick();
        check("mid_serial", {7'd0, serial_out}, 8'd0);
        check("mid_link", {7'd0, link_up}, 8'd0);
        check("mid_ready", {7'd0, ready_out}, 8'd0);
        reset = 1'b0;

        // Restarted preamble, with a receiver-side COM counter / IDLE detector
        com_seen  = 0;
        idle_flag = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sym($sformatf("re_com%0d", k), 8, 8, 8'h00, 8'hBC, 8'h00);
            com_seen++;
            check($sformatf("re_com%0d_link", k), {7'd0, link_up}, (k == 3) ? 8'd1 : 8'd0);
        end
        check("rx_idle_pre", {7'd0, idle_flag}, 8'd0);
        sym("re_idle", 8, 8, 8'h00, 8'h7C, 8'h40);
        if (com_seen >= 4) idle_flag = 1'b1;
        check("rx_idle_post", {7'd0, idle_flag}, 8'd1);

`ifdef PS_TX_REALIGN_EN
        begin
            logic [7:0] s;
            logic [7:0] rm;
            s  = 8'h00;
            rm = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (i == 2) realign_req = 1'b1;
                if (i == 3) realign_req = 1'b0;
                tick();
                s[7-i] = serial_out;
                rm[i]  = ready_out;
            end
            check("ra_cur_sym", s, 8'h7C);
            check("ra_cur_ready", rm, 8'h00);
            for (int k = 0; k < 4; k++) begin
                sym($sformatf("ra_com%0d", k), 8, 8, 8'h00, 8'hBC, 8'h00);
                check($sformatf("ra_com%0d_link", k), {7'd0, link_up}, (k == 3) ? 8'd1 : 8'd0);
            end
            sym("ra_idle", 8, 8, 8'h00, 8'h7C, 8'h40);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
